lsu_pipe: RTL and testbench

- Parametrised multi-cycle load/store unit that replaces the single-cycle memory stage of the RV64 pipeline.
- Sits between the ex_mem pipeline register and mem_wb, and talks to an external memory bus through a request/grant/response handshake.
- Handles byte-lane masking, load alignment and sign/zero extension, misalignment detection and bus timeout.
- Raises a stall to ctrl while a transaction is in flight.

---
 rtl/lsu_pipe_if.sv | 30 +++
 rtl/lsu_pipe.sv | 206 ++++++++++++++++++++
 tb/tb_lsu_pipe.sv | 312 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/lsu_pipe_if.sv
`default_nettype none
// ============================================================================
// Module   : lsu_pipe_if
// Brief    : Memory bus bundle between the load/store unit and external memory.
// Revision : 1.0
// ============================================================================
interface lsu_pipe_if #(
    parameter int XLEN = 64,
    parameter int AW   = 64
);
    logic                bus_req_o;
    logic                bus_we_o;
    logic [AW-1:0]       bus_addr_o;
    logic [XLEN-1:0]     bus_wdata_o;
    logic [XLEN/8-1:0]   bus_wmask_o;
    logic                bus_gnt_i;
    logic                bus_rvalid_i;
    logic [XLEN-1:0]     bus_rdata_i;

    modport master (
        output bus_req_o, bus_we_o, bus_addr_o, bus_wdata_o, bus_wmask_o,
        input  bus_gnt_i, bus_rvalid_i, bus_rdata_i
    );

    modport slave (
        input  bus_req_o, bus_we_o, bus_addr_o, bus_wdata_o, bus_wmask_o,
        output bus_gnt_i, bus_rvalid_i, bus_rdata_i
    );
endinterface
`default_nettype wire

// File: rtl/lsu_pipe.sv
`default_nettype none
// ============================================================================
// Module   : lsu_pipe
// Brief    : Multi-cycle load/store unit with lane masking, load extension,
//            misalignment detection and bus timeout.
// Revision : 1.0
// ============================================================================
module lsu_pipe #(
    parameter int XLEN    = 64,
    parameter int AW      = 64,
    parameter int TIMEOUT = 255
) (
    input  wire logic              clk,
    input  wire logic              rst,
    input  wire logic              req_valid_i,
    input  wire logic              req_wen_i,
    input  wire logic [1:0]        req_size_i,
    input  wire logic              req_unsigned_i,
    input  wire logic [AW-1:0]     req_addr_i,
    input  wire logic [XLEN-1:0]   req_wdata_i,
    input  wire logic [4:0]        rd_waddr_i,
    input  wire logic              flush_i,
    output logic                   stall_o,
    output logic                   resp_valid_o,
    output logic [XLEN-1:0]        rd_wdata_o,
    output logic [4:0]             rd_waddr_o,
    output logic                   reg_wen_o,
    output logic                   misalign_o,
    output logic                   err_o,
    lsu_pipe_if.master             bus
);

    localparam int c_NB = XLEN / 8;
    localparam int c_OW = $clog2(c_NB);
    localparam int c_CW = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);
    localparam logic [c_CW-1:0] c_TO_LAST = c_CW'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_REQ  = 2'd1,
        S_WAIT = 2'd2
    } state_t;

    state_t              r_state;
    state_t              w_next;
    logic [c_CW-1:0]     r_cnt;
    logic [AW-1:0]       r_addr;
    logic [XLEN-1:0]     r_wdata;
    logic [c_NB-1:0]     r_mask;
    logic                r_wen;
    logic [1:0]          r_size;
    logic                r_uns;
    logic [c_OW-1:0]     r_off;
    logic [4:0]          r_rd;
    logic                r_kill;

    logic [c_OW-1:0]     w_off;
    logic                w_misal;
    logic                w_accept;
    logic                w_mis_pulse;
    logic [7:0]          w_lanes;
    logic [c_NB-1:0]     w_mask;
    logic                w_done;
    logic                w_timeout;
    logic                w_to_hit;
    logic                w_resp;
    logic [XLEN-1:0]     w_rsh;
    logic [63:0]         w_rsh64;
    logic [63:0]         w_ext;
    logic                w_sbit;

    assign w_off = req_addr_i[c_OW-1:0];

    always_comb begin
        w_misal = 1'b0;
        w_lanes = 8'h01;
        case (req_size_i)
            2'd0: begin w_misal = 1'b0;                          w_lanes = 8'h01; end
            2'd1: begin w_misal = w_off[0];                      w_lanes = 8'h03; end
            2'd2: begin w_misal = |w_off[1:0];                   w_lanes = 8'h0F; end
            default: begin w_misal = (|w_off) || (XLEN == 32);   w_lanes = 8'hFF; end
        endcase
    end

    assign w_mask      = w_lanes[c_NB-1:0] << w_off;
    // Reset gating keeps stall_o low while rst is held, even with an op waiting.
    assign w_accept    = !rst && (r_state == S_IDLE) && req_valid_i && !w_misal && !flush_i;
    assign w_mis_pulse = (r_state == S_IDLE) && req_valid_i && w_misal && !flush_i;
    assign w_to_hit    = (TIMEOUT != 0) && (r_cnt == c_TO_LAST);

    always_comb begin
        w_next    = r_state;
        w_done    = 1'b0;
        w_timeout = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (w_accept) w_next = S_REQ;
            end
            S_REQ: begin
                if (bus.bus_gnt_i) begin
                    if (bus.bus_rvalid_i) begin
                        w_done = 1'b1;
                        w_next = S_IDLE;
                    end else begin
                        w_next = S_WAIT;
                    end
                end else if (flush_i) begin
                    w_next = S_IDLE;
                end else if (w_to_hit) begin
                    w_timeout = 1'b1;
                    w_next    = S_IDLE;
                end
            end
            S_WAIT: begin
                if (bus.bus_rvalid_i) begin
                    w_done = 1'b1;
                    w_next = S_IDLE;
                end else if (w_to_hit) begin
                    w_timeout = 1'b1;
                    w_next    = S_IDLE;
                end
            end
            default: w_next = S_IDLE;
        endcase
    end

    // A flush arriving in the completion cycle still suppresses the response.
    assign w_resp  = w_done && !(r_kill || flush_i);
    assign stall_o = w_accept || ((r_state != S_IDLE) && !w_done && !w_timeout);

    assign w_rsh   = bus.bus_rdata_i >> {r_off, 3'b000};
    assign w_rsh64 = 64'(w_rsh);

    always_comb begin
        w_sbit = 1'b0;
        w_ext  = w_rsh64;
        case (r_size)
            2'd0: begin w_sbit = !r_uns && w_rsh64[7];  w_ext = {{56{w_sbit}}, w_rsh64[7:0]};  end
            2'd1: begin w_sbit = !r_uns && w_rsh64[15]; w_ext = {{48{w_sbit}}, w_rsh64[15:0]}; end
            2'd2: begin w_sbit = !r_uns && w_rsh64[31]; w_ext = {{32{w_sbit}}, w_rsh64[31:0]}; end
            default: begin w_sbit = 1'b0;               w_ext = w_rsh64;                       end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_cnt   <= '0;
            r_kill  <= 1'b0;
        end else begin
            r_state <= w_next;
            if (r_state != w_next)      r_cnt <= '0;
            else if (r_state != S_IDLE) r_cnt <= r_cnt + 1'b1;
            if ((r_state != S_IDLE) && (w_next != S_IDLE)) r_kill <= r_kill || flush_i;
            else                                           r_kill <= 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_addr  <= '0;
            r_wdata <= '0;
            r_mask  <= '0;
            r_wen   <= 1'b0;
            r_size  <= 2'd0;
            r_uns   <= 1'b0;
            r_off   <= '0;
            r_rd    <= 5'd0;
        end else if (w_accept) begin
            r_addr  <= {req_addr_i[AW-1:c_OW], {c_OW{1'b0}}};
            r_wdata <= req_wdata_i << {w_off, 3'b000};
            r_mask  <= req_wen_i ? w_mask : {c_NB{1'b1}};
            r_wen   <= req_wen_i;
            r_size  <= req_size_i;
            r_uns   <= req_unsigned_i;
            r_off   <= w_off;
            r_rd    <= rd_waddr_i;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            resp_valid_o <= 1'b0;
            reg_wen_o    <= 1'b0;
            rd_waddr_o   <= 5'd0;
            rd_wdata_o   <= '0;
            misalign_o   <= 1'b0;
            err_o        <= 1'b0;
        end else begin
            resp_valid_o <= w_resp;
            reg_wen_o    <= w_resp && !r_wen;
            rd_waddr_o   <= w_resp ? r_rd : 5'd0;
            rd_wdata_o   <= (w_resp && !r_wen) ? w_ext[XLEN-1:0] : '0;
            misalign_o   <= w_mis_pulse;
            err_o        <= w_timeout;
        end
    end

    assign bus.bus_req_o   = (r_state == S_REQ);
    assign bus.bus_we_o    = (r_state == S_REQ) && r_wen;
    assign bus.bus_addr_o  = r_addr;
    assign bus.bus_wdata_o = r_wdata;
    assign bus.bus_wmask_o = r_mask;

endmodule
`default_nettype wire

// File: tb/tb_lsu_pipe.sv
`default_nettype none
// ============================================================================
// Module   : tb_lsu_pipe
// Brief    : Directed self-checking bench for lsu_pipe (XLEN=64, TIMEOUT=4).
// Revision : 1.0
// ============================================================================
module tb_lsu_pipe;

    logic        clk;
    logic        rst;
    logic        req_valid;
    logic        req_wen;
    logic [1:0]  req_size;
    logic        req_uns;
    logic [63:0] req_addr;
    logic [63:0] req_wdata;
    logic [4:0]  rd_waddr;
    logic        flush;
    logic        stall;
    logic        resp_valid;
    logic [63:0] rd_wdata;
    logic [4:0]  rd_waddr_out;
    logic        reg_wen;
    logic        misalign;
    logic        err;

    int n_chk;
    int n_bad;
    int n_stall;

    lsu_pipe_if #(.XLEN(64), .AW(64)) bus_if ();

    lsu_pipe #(.XLEN(64), .AW(64), .TIMEOUT(4)) dut (
        .clk            (clk),
        .rst            (rst),
        .req_valid_i    (req_valid),
        .req_wen_i      (req_wen),
        .req_size_i     (req_size),
        .req_unsigned_i (req_uns),
        .req_addr_i     (req_addr),
        .req_wdata_i    (req_wdata),
        .rd_waddr_i     (rd_waddr),
        .flush_i        (flush),
        .stall_o        (stall),
        .resp_valid_o   (resp_valid),
        .rd_wdata_o     (rd_wdata),
        .rd_waddr_o     (rd_waddr_out),
        .reg_wen_o      (reg_wen),
        .misalign_o     (misalign),
        .err_o          (err),
        .bus            (bus_if)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk = n_chk + 1;
        if (got !== exp) begin
            n_bad = n_bad + 1;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_op(input logic wen, input logic [1:0] size, input logic uns,
                          input logic [63:0] addr, input logic [63:0] wdata, input logic [4:0] rd);
        req_valid = 1'b1;
        req_wen   = wen;
        req_size  = size;
        req_uns   = uns;
        req_addr  = addr;
        req_wdata = wdata;
        rd_waddr  = rd;
    endtask

    task automatic clear_op();
        req_valid = 1'b0;
        req_wen   = 1'b0;
        req_size  = 2'd0;
        req_uns   = 1'b0;
        req_addr  = 64'd0;
        req_wdata = 64'd0;
        rd_waddr  = 5'd0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        n_chk = 0;
        n_bad = 0;
        rst   = 1'b1;
        flush = 1'b0;
        clear_op();
        bus_if.bus_gnt_i    = 1'b0;
        bus_if.bus_rvalid_i = 1'b0;
        bus_if.bus_rdata_i  = 64'd0;
        step();
        step();
        check("rst_stall", stall, 0);
        check("rst_resp", resp_valid, 0);
        check("rst_busreq", bus_if.bus_req_o, 0);
        check("rst_wmask", bus_if.bus_wmask_o, 0);
        check("rst_err", err, 0);
        rst = 1'b0;
        step();

        // Signed byte load at offset 3, gnt at +1, rvalid 3 cycles after gnt.
        n_stall = 0;
        set_op(1'b0, 2'd0, 1'b0, 64'h8000_0003, 64'd0, 5'd3);
        #1; if (stall) n_stall++;
        step();
        bus_if.bus_gnt_i = 1'b1;
        #1; if (stall) n_stall++;
        check("lb_busreq", bus_if.bus_req_o, 1);
        check("lb_addr", bus_if.bus_addr_o, 64'h8000_0000);
        check("lb_wmask", bus_if.bus_wmask_o, 64'hFF);
        check("lb_we", bus_if.bus_we_o, 0);
        step();
        bus_if.bus_gnt_i = 1'b0;
        #1; if (stall) n_stall++;
        step();
        #1; if (stall) n_stall++;
        step();
        bus_if.bus_rvalid_i = 1'b1;
        bus_if.bus_rdata_i  = 64'h0000_0000_8000_0000;
        #1;
        check("lb_stall_rel", stall, 0);
        step();
        bus_if.bus_rvalid_i = 1'b0;
        clear_op();
        #1;
        check("lb_resp", resp_valid, 1);
        check("lb_data", rd_wdata, 64'hFFFF_FFFF_FFFF_FF80);
        check("lb_regwen", reg_wen, 1);
        check("lb_rd", rd_waddr_out, 5'd3);
        check("lb_stall_cycles", n_stall, 4);
        step();
        check("lb_resp_pulse", resp_valid, 0);

        // Store half at offset 6.
        set_op(1'b1, 2'd1, 1'b0, 64'h1000_0006, 64'hABCD, 5'd0);
        #1;
        check("sh_stall", stall, 1);
        step();
        bus_if.bus_gnt_i = 1'b1;
        #1;
        check("sh_we", bus_if.bus_we_o, 1);
        check("sh_wmask", bus_if.bus_wmask_o, 64'hC0);
        check("sh_wdata", bus_if.bus_wdata_o, 64'hABCD_0000_0000_0000);
        check("sh_addr", bus_if.bus_addr_o, 64'h1000_0000);
        step();
        bus_if.bus_gnt_i    = 1'b0;
        bus_if.bus_rvalid_i = 1'b1;
        #1;
        check("sh_stall_rel", stall, 0);
        step();
        bus_if.bus_rvalid_i = 1'b0;
        clear_op();
        #1;
        check("sh_resp", resp_valid, 1);
        check("sh_regwen", reg_wen, 0);
        check("sh_data", rd_wdata, 64'd0);
        step();

        // Misaligned word load.
        set_op(1'b0, 2'd2, 1'b0, 64'h1000_0002, 64'd0, 5'd4);
        #1;
        check("mis_busreq", bus_if.bus_req_o, 0);
        check("mis_stall", stall, 0);
        step();
        clear_op();
        #1;
        check("mis_pulse", misalign, 1);
        check("mis_resp", resp_valid, 0);
        check("mis_stall2", stall, 0);
        step();
        check("mis_pulse_end", misalign, 0);

        // Grant never arrives: timeout after 4 cycles in REQ.
        set_op(1'b0, 2'd3, 1'b0, 64'h3000_0000, 64'd0, 5'd6);
        #1;
        step();
        for (int i = 1; i <= 4; i++) begin
            #1;
            check("to_busreq", bus_if.bus_req_o, 1);
            check("to_stall", stall, (i == 4) ? 64'd0 : 64'd1);
            if (i == 4) clear_op();
            step();
        end
        check("to_err", err, 1);
        check("to_busreq_off", bus_if.bus_req_o, 0);
        check("to_stall_off", stall, 0);
        bus_if.bus_rvalid_i = 1'b1;
        bus_if.bus_rdata_i  = 64'h1;
        step();
        bus_if.bus_rvalid_i = 1'b0;
        #1;
        check("to_late_resp", resp_valid, 0);
        check("to_err_end", err, 0);

        // Flush during WAIT of a load to rd=5.
        set_op(1'b0, 2'd2, 1'b0, 64'h4000_0004, 64'd0, 5'd5);
        #1;
        step();
        bus_if.bus_gnt_i = 1'b1;
        #1;
        step();
        bus_if.bus_gnt_i = 1'b0;
        flush = 1'b1;
        #1;
        check("fl_stall", stall, 1);
        step();
        flush = 1'b0;
        bus_if.bus_rvalid_i = 1'b1;
        bus_if.bus_rdata_i  = 64'h1234_5678_0000_0000;
        #1;
        check("fl_stall_rel", stall, 0);
        step();
        bus_if.bus_rvalid_i = 1'b0;
        clear_op();
        #1;
        check("fl_resp", resp_valid, 0);
        check("fl_regwen", reg_wen, 0);
        set_op(1'b0, 2'd3, 1'b0, 64'h4000_0008, 64'd0, 5'd7);
        #1;
        check("fl_next_stall", stall, 1);
        step();
        bus_if.bus_gnt_i = 1'b1;
        step();
        bus_if.bus_gnt_i    = 1'b0;
        bus_if.bus_rvalid_i = 1'b1;
        bus_if.bus_rdata_i  = 64'h1122_3344_5566_7788;
        step();
        bus_if.bus_rvalid_i = 1'b0;
        clear_op();
        #1;
        check("fl_next_resp", resp_valid, 1);
        check("fl_next_data", rd_wdata, 64'h1122_3344_5566_7788);
        check("fl_next_rd", rd_waddr_out, 5'd7);
        step();

        // Back-to-back loads on a zero-latency bus, then reset mid-WAIT.
        set_op(1'b0, 2'd1, 1'b1, 64'h2000_0004, 64'd0, 5'd8);
        #1;
        check("bb_stall1", stall, 1);
        step();
        bus_if.bus_gnt_i    = 1'b1;
        bus_if.bus_rvalid_i = 1'b1;
        bus_if.bus_rdata_i  = 64'h0000_BEEF_0000_0000;
        #1;
        check("bb_busreq1", bus_if.bus_req_o, 1);
        check("bb_stall_rel1", stall, 0);
        step();
        set_op(1'b0, 2'd2, 1'b0, 64'h2000_0000, 64'd0, 5'd10);
        bus_if.bus_gnt_i    = 1'b0;
        bus_if.bus_rvalid_i = 1'b0;
        #1;
        check("bb_resp1", resp_valid, 1);
        check("bb_data1", rd_wdata, 64'h0000_0000_0000_BEEF);
        check("bb_rd1", rd_waddr_out, 5'd8);
        check("bb_stall2", stall, 1);
        step();
        bus_if.bus_gnt_i    = 1'b1;
        bus_if.bus_rvalid_i = 1'b1;
        bus_if.bus_rdata_i  = 64'h0000_0000_8765_4321;
        #1;
        check("bb_gap", resp_valid, 0);
        check("bb_stall_rel2", stall, 0);
        step();
        set_op(1'b0, 2'd3, 1'b0, 64'h2000_0008, 64'd0, 5'd9);
        bus_if.bus_gnt_i    = 1'b0;
        bus_if.bus_rvalid_i = 1'b0;
        #1;
        check("bb_resp2", resp_valid, 1);
        check("bb_data2", rd_wdata, 64'hFFFF_FFFF_8765_4321);
        check("bb_rd2", rd_waddr_out, 5'd10);
        step();
        bus_if.bus_gnt_i = 1'b1;
        step();
        bus_if.bus_gnt_i = 1'b0;
        #1;
        check("rw_stall_wait", stall, 1);
        rst = 1'b1;
        #1;
        check("rw_stall", stall, 0);
        check("rw_busreq", bus_if.bus_req_o, 0);
        check("rw_addr", bus_if.bus_addr_o, 64'd0);
        check("rw_resp", resp_valid, 0);
        check("rw_regwen", reg_wen, 0);
        check("rw_data", rd_wdata, 64'd0);
        check("rw_rd", rd_waddr_out, 5'd0);
        clear_op();
        step();
        rst = 1'b0;
        step();
        check("rw_after", resp_valid, 0);

        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
